// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch (IF) port, the load/store (D) port and the
// shared single-ported memory port of mem_port_arbiter.
//   slave  : the arbiter's view (requests and memory read data in; acks, read data,
//            stalls and memory strobes out)
//   master : the environment's view (requesters plus memory)
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    // Shared memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between the fetch port
// and the load/store port. One access at a time: IDLE (arbitrate, strobe mem_en) ->
// BUSY (wait MEM_LAT cycles, capture read data) -> RESP (1-cycle ack) -> IDLE.
// D wins conflicts unless fetch has lost STARVE_MAX consecutive grants.
// Ports:
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset; abandons any in-flight access
//   bus   mem_port_arbiter_if.slave: IF/D request ports and memory port
//   busy  high whenever the FSM is not idle
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);

    localparam int unsigned CntW    = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int unsigned StreakW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
    typedef enum logic {OwnD, OwnIf} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                we_q, we_d;          // current access is a store
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [StreakW-1:0]  streak_q, streak_d;  // consecutive D grants while IF waited
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant_if;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_if    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.if_req || bus.d_req) begin
                    // Fetch only wins a conflict once it has been starved long enough
                    grant_if = bus.if_req &&
                               (!bus.d_req || (streak_q == StreakW'(STARVE_MAX)));
                    owner_d     = grant_if ? OwnIf : OwnD;
                    we_d        = !grant_if && bus.d_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = !grant_if && bus.d_we;
                    mem_addr_d  = grant_if ? bus.if_addr : bus.d_addr;
                    mem_wdata_d = grant_if ? '0 : bus.d_wdata;
                    cnt_d       = '0;
                    if (grant_if || !bus.if_req) begin
                        streak_d = '0;
                    end else begin
                        streak_d = streak_q + StreakW'(1);
                    end
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CntW'(1);
                // mem_rdata is valid in the cycle where cnt reaches MEM_LAT
                if (cnt_q == CntW'(MEM_LAT)) begin
                    if (owner_q == OwnIf) begin
                        if_rdata_d = bus.mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d = we_q ? '0 : bus.mem_rdata;
                        d_ack_d   = 1'b1;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnD;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    // Stalls are combinational so the pipeline can advance in the ack cycle itself
    assign bus.if_stall  = bus.if_req & ~if_ack_q;
    assign bus.d_stall   = bus.d_req & ~d_ack_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_LAT    = 1;
    localparam int unsigned STARVE_MAX = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
    } grant_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;

    grant_t      grant_q[$];
    resp_t       resp_q[$];
    logic [31:0] mem[logic [31:0]];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Memory model, MEM_LAT = 1: data for an access appears the cycle after mem_en
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] = bus.mem_wdata;
                bus.mem_rdata <= 32'hFFFF_FFFF;
            end else begin
                bus.mem_rdata <= mem_read(bus.mem_addr);
            end
        end else begin
            bus.mem_rdata <= 32'hBAD0_BAD0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        grant_t g;
        resp_t  r;
        check("if_stall", bus.if_stall, bus.if_req & ~bus.if_ack);
        check("d_stall", bus.d_stall, bus.d_req & ~bus.d_ack);
        if (bus.mem_en) begin
            check("grant_expected", grant_q.size() != 0, 1);
            if (grant_q.size() != 0) begin
                g = grant_q.pop_front();
                check("grant_cycle", cyc, g.cyc);
                check("mem_addr", bus.mem_addr, g.addr);
                check("mem_we", bus.mem_we, g.we);
                if (g.we) check("mem_wdata", bus.mem_wdata, g.wdata);
            end
        end
        if (bus.if_ack || bus.d_ack) begin
            check("ack_exclusive", bus.if_ack & bus.d_ack, 0);
            check("ack_expected", resp_q.size() != 0, 1);
            if (resp_q.size() != 0) begin
                r = resp_q.pop_front();
                check("ack_port", bus.d_ack, r.is_d);
                check("ack_cycle", cyc, r.cyc);
                check("ack_rdata", r.is_d ? bus.d_rdata : bus.if_rdata, r.data);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit is_d, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = is_d ? bus.d_ack : bus.if_ack;
        end
        check(is_d ? "d_ack_timeout" : "if_ack_timeout", seen, 1);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          is_if;
        bit          seen;
        logic [31:0] a;

        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        mem[32'h100] = 32'hDEAD_BEEF;

        // Reset held two cycles with both requests high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_if_ack", bus.if_ack, 0);
        check("rst_d_ack", bus.d_ack, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_busy", busy, 0);
        #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        rst        = 1'b0;
        next();

        // Single fetch
        next();
        t0 = cyc;
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        grant_q.push_back('{32'h100, 1'b0, 32'h0, t0 + 1});
        resp_q.push_back('{1'b0, 32'hDEAD_BEEF, t0 + 3});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("fetch_busy", busy, (i >= 1 && i <= 3));
            if (bus.if_ack) begin
                #1;
                bus.if_req = 1'b0;
            end
        end

        // Conflict: D first, IF next
        next();
        t0 = cyc;
        bus.d_addr  = 32'h2000;
        bus.d_we    = 1'b0;
        bus.d_req   = 1'b1;
        bus.if_addr = 32'h104;
        bus.if_req  = 1'b1;
        grant_q.push_back('{32'h2000, 1'b0, 32'h0, t0 + 1});
        resp_q.push_back('{1'b1, mem_read(32'h2000), t0 + 3});
        grant_q.push_back('{32'h104, 1'b0, 32'h0, t0 + 5});
        resp_q.push_back('{1'b0, mem_read(32'h104), t0 + 7});
        wait_ack(1'b1, 10);
        bus.d_req = 1'b0;
        wait_ack(1'b0, 10);
        bus.if_req = 1'b0;

        // Starvation guard: both keep requesting
        next();
        t0 = cyc;
        bus.if_addr = 32'h500;
        bus.if_req  = 1'b1;
        bus.d_addr  = 32'h3000;
        bus.d_req   = 1'b1;
        for (int g = 0; g < 10; g++) begin
            is_if = (g == 4 || g == 9);
            a = is_if ? bus.if_addr : bus.d_addr;
            grant_q.push_back('{a, 1'b0, 32'h0, t0 + 4 * g + 1});
            resp_q.push_back('{!is_if, mem_read(a), t0 + 4 * g + 3});
            wait_ack(!is_if, 12);
            if (is_if) bus.if_addr = bus.if_addr + 32'd4;
            else bus.d_addr = bus.d_addr + 32'd4;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;

        // Store, then read it back
        next();
        t0 = cyc;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h40;
        bus.d_wdata = 32'h1234_5678;
        bus.d_req   = 1'b1;
        grant_q.push_back('{32'h40, 1'b1, 32'h1234_5678, t0 + 1});
        resp_q.push_back('{1'b1, 32'h0, t0 + 3});
        wait_ack(1'b1, 10);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        next();
        t0 = cyc;
        bus.d_req = 1'b1;
        grant_q.push_back('{32'h40, 1'b0, 32'h0, t0 + 1});
        resp_q.push_back('{1'b1, 32'h1234_5678, t0 + 3});
        wait_ack(1'b1, 10);
        bus.d_req = 1'b0;

        // Reset during BUSY abandons the access
        next();
        t0 = cyc;
        bus.d_addr = 32'h2400;
        bus.d_req  = 1'b1;
        grant_q.push_back('{32'h2400, 1'b0, 32'h0, t0 + 1});
        next();
        next();
        rst       = 1'b1;
        bus.d_req = 1'b0;
        next();
        check("midrst_busy", busy, 0);
        check("midrst_mem_en", bus.mem_en, 0);
        check("midrst_d_ack", bus.d_ack, 0);
        check("midrst_d_rdata", bus.d_rdata, 0);
        check("midrst_mem_addr", bus.mem_addr, 0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | bus.d_ack | bus.if_ack;
        end
        check("midrst_no_ack", seen, 0);

        check("grant_q_drained", grant_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
